// File: rtl/byte_memory.sv
// Byte-addressable load/store memory with byte-lane strobes, load extension,
// misalignment detection and a fixed-latency response pipeline.
module byte_memory #(
  parameter  int NUMWORDS   = 4096,
  parameter  int DATAWIDTH  = 32,
  parameter  int RD_LATENCY = 1,
  localparam int NBYTES     = DATAWIDTH / 8,
  localparam int ADDRWIDTH  = $clog2(NUMWORDS) + $clog2(NBYTES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [1:0]           size_i,
  input  logic                 unsigned_i,
  input  logic [ADDRWIDTH-1:0] addr_i,
  input  logic [DATAWIDTH-1:0] wdata_i,
  output logic                 rvalid_o,
  output logic [DATAWIDTH-1:0] rdata_o,
  output logic                 err_o
);

  localparam int OFFW  = $clog2(NBYTES);
  localparam int WORDW = $clog2(NUMWORDS);

  // Handshake: req_i has no ready; every request is accepted at the clock edge
  // where it is high and is answered by exactly one rvalid_o pulse RD_LATENCY
  // cycles later (stores and errors included).

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic                 err;
    logic [1:0]           size;
    logic                 uns;
    logic [OFFW-1:0]      off;
    logic [DATAWIDTH-1:0] word;
  } stage_t;

  logic [DATAWIDTH-1:0] mem [NUMWORDS];

  logic [OFFW-1:0]      req_off;
  logic [WORDW-1:0]     req_idx;
  logic [3:0]           acc_bytes;
  logic                 req_err;
  logic [15:0]          strb_w;
  logic [NBYTES-1:0]    strb;
  logic [DATAWIDTH-1:0] wdata_sh;
  stage_t               cap;
  stage_t               pipe [RD_LATENCY];
  stage_t               last;

  always_comb begin
    req_off   = addr_i[OFFW-1:0];
    req_idx   = addr_i[ADDRWIDTH-1:OFFW];
    acc_bytes = 4'd1 << size_i;
    req_err   = ((size_i == 2'b11) && (DATAWIDTH == 32)) ||
                ((4'(req_off) & (acc_bytes - 4'd1)) != 4'd0);
    strb_w    = ((16'd1 << acc_bytes) - 16'd1) << req_off;
    strb      = strb_w[NBYTES-1:0];
    wdata_sh  = wdata_i << {req_off, 3'b000};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUMWORDS; i++) mem[i] <= '0;
    end else if (req_i && we_i && !req_err) begin
      for (int b = 0; b < NBYTES; b++)
        if (strb[b]) mem[req_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    end
  end

  // The raw word is sampled before the edge, so a same-cycle store is not seen.
  always_comb begin
    cap       = '0;
    cap.valid = req_i;
    cap.we    = we_i;
    cap.err   = req_err;
    cap.size  = size_i;
    cap.uns   = unsigned_i;
    cap.off   = req_off;
    cap.word  = mem[req_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= cap;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic [DATAWIDTH-1:0] shifted;
  logic [DATAWIDTH-1:0] mask;
  logic                 sign;
  int                   nbits;

  // Extension uses a low-bits mask; its top set bit selects the sign bit.
  always_comb begin
    last    = pipe[RD_LATENCY-1];
    shifted = last.word >> {last.off, 3'b000};
    nbits   = 8 << last.size;
    if (nbits > DATAWIDTH) nbits = DATAWIDTH;
    mask    = {DATAWIDTH{1'b1}} >> (DATAWIDTH - nbits);
    sign    = !last.uns && (|(shifted & mask & ~(mask >> 1)));
    rvalid_o = last.valid;
    err_o    = last.valid && last.err;
    rdata_o  = '0;
    if (last.valid && !last.we && !last.err)
      rdata_o = (shifted & mask) | (sign ? ~mask : '0);
  end

endmodule

// File: tb/tb_byte_memory.sv
// Directed bench for byte_memory: three instances (32b lat1, 32b lat3, 64b lat2)
// share one request stream and are checked cycle by cycle against hand values.
module tb_byte_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [8:0]  addr;
  logic [63:0] wdata;

  logic        rv1, er1, rv3, er3, rv6, er6;
  logic [31:0] rd1, rd3;
  logic [63:0] rd6;

  int checks = 0;
  int errors = 0;
  string step;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [8:0]  addr;
    logic [63:0] wdata;
    logic [63:0] e32;
    logic [63:0] e64;
    logic        r32;
    logic        r64;
  } txn_t;
  txn_t tq[$];

  always #5 clk = ~clk;

  byte_memory #(.NUMWORDS(64), .DATAWIDTH(32), .RD_LATENCY(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr[7:0]), .wdata_i(wdata[31:0]),
    .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1));

  byte_memory #(.NUMWORDS(64), .DATAWIDTH(32), .RD_LATENCY(3)) u_d3 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr[7:0]), .wdata_i(wdata[31:0]),
    .rvalid_o(rv3), .rdata_o(rd3), .err_o(er3));

  byte_memory #(.NUMWORDS(64), .DATAWIDTH(64), .RD_LATENCY(2)) u_d64 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
    .rvalid_o(rv6), .rdata_o(rd6), .err_o(er6));

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%h expected=%h", step, tag, obs, exp);
    end
  endtask

  task automatic add(logic w, logic [1:0] s, logic u, logic [8:0] a, logic [63:0] d,
                     logic [63:0] e32, logic [63:0] e64, logic r32, logic r64);
    txn_t t;
    t.we = w; t.size = s; t.uns = u; t.addr = a; t.wdata = d;
    t.e32 = e32; t.e64 = e64; t.r32 = r32; t.r64 = r64;
    tq.push_back(t);
  endtask

  task automatic check_dut(string name, int k, int lat, logic rv, logic [63:0] rd,
                           logic er, bit use64);
    int j;
    logic ev, ee;
    logic [63:0] ed;
    j = k - lat;
    if (j >= 0 && j < tq.size()) begin
      ev = 1'b1;
      ed = use64 ? tq[j].e64 : tq[j].e32;
      ee = use64 ? tq[j].r64 : tq[j].r32;
    end else begin
      ev = 1'b0; ed = '0; ee = 1'b0;
    end
    chk($sformatf("%s_c%0d_rvalid", name, k), {63'b0, rv}, {63'b0, ev});
    chk($sformatf("%s_c%0d_rdata", name, k), rd, ed);
    chk($sformatf("%s_c%0d_err", name, k), {63'b0, er}, {63'b0, ee});
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
  endtask

  // Issues the queued requests back-to-back and checks every cycle of every DUT.
  task automatic burst();
    int n;
    n = tq.size();
    for (int k = 0; k <= n + 4; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check_dut("d1", k, 1, rv1, {32'b0, rd1}, er1, 1'b0);
        check_dut("d3", k, 3, rv3, {32'b0, rd3}, er3, 1'b0);
        check_dut("d64", k, 2, rv6, rd6, er6, 1'b1);
      end
      if (k < n) begin
        req = 1'b1; we = tq[k].we; size = tq[k].size; uns = tq[k].uns;
        addr = tq[k].addr; wdata = tq[k].wdata;
      end else begin
        idle_inputs();
      end
    end
    tq.delete();
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_d1_rvalid"}, {63'b0, rv1}, 64'd0);
    chk({tag, "_d1_rdata"}, {32'b0, rd1}, 64'd0);
    chk({tag, "_d1_err"}, {63'b0, er1}, 64'd0);
    chk({tag, "_d3_rvalid"}, {63'b0, rv3}, 64'd0);
    chk({tag, "_d3_rdata"}, {32'b0, rd3}, 64'd0);
    chk({tag, "_d3_err"}, {63'b0, er3}, 64'd0);
    chk({tag, "_d64_rvalid"}, {63'b0, rv6}, 64'd0);
    chk({tag, "_d64_rdata"}, rd6, 64'd0);
    chk({tag, "_d64_err"}, {63'b0, er6}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    step = "reset";
    check_quiet("rst");
    rst = 1'b0;

    step = "t1_load_zero";
    add(0, 2'b10, 0, 9'h000, 0, 64'h0, 64'h0, 0, 0);
    burst();

    step = "t2_extend";
    add(1, 2'b10, 0, 9'h010, 64'h80FF7F01, 0, 0, 0, 0);
    add(0, 2'b00, 1, 9'h011, 0, 64'h7F, 64'h7F, 0, 0);
    add(0, 2'b00, 0, 9'h013, 0, 64'hFFFFFF80, 64'hFFFFFFFFFFFFFF80, 0, 0);
    add(0, 2'b01, 0, 9'h012, 0, 64'hFFFF80FF, 64'hFFFFFFFFFFFF80FF, 0, 0);
    burst();

    step = "t3_byte_store";
    add(1, 2'b10, 0, 9'h020, 64'h11223344, 0, 0, 0, 0);
    add(1, 2'b00, 0, 9'h022, 64'hAA, 0, 0, 0, 0);
    add(0, 2'b10, 1, 9'h020, 0, 64'h11AA3344, 64'h11AA3344, 0, 0);
    burst();

    step = "t4_misalign";
    add(1, 2'b10, 0, 9'h004, 64'hCAFEBABE, 0, 0, 0, 0);
    add(0, 2'b01, 0, 9'h001, 0, 0, 0, 1, 1);
    add(1, 2'b10, 0, 9'h006, 64'hDEADBEEF, 0, 0, 1, 1);
    add(0, 2'b10, 1, 9'h004, 0, 64'hCAFEBABE, 64'hCAFEBABE, 0, 0);
    burst();

    step = "t5_back_to_back";
    add(1, 2'b10, 0, 9'h040, 64'h12345678, 0, 0, 0, 0);
    add(0, 2'b10, 0, 9'h040, 0, 64'h12345678, 64'h12345678, 0, 0);
    burst();

    step = "t6_doubleword";
    add(1, 2'b11, 0, 9'h008, 64'h0123456789ABCDEF, 0, 0, 1, 0);
    add(0, 2'b11, 0, 9'h008, 0, 0, 64'h0123456789ABCDEF, 1, 0);
    add(0, 2'b01, 1, 9'h00E, 0, 64'h0, 64'h0123, 0, 0);
    burst();

    step = "t7_reset_in_flight";
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 9'h010;
    @(negedge clk);
    addr = 9'h020;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_quiet("in_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_quiet($sformatf("post_rst_c%0d", k));
    end

    step = "t8_cleared";
    add(0, 2'b10, 0, 9'h010, 0, 64'h0, 64'h0, 0, 0);
    add(0, 2'b10, 0, 9'h020, 0, 64'h0, 64'h0, 0, 0);
    add(0, 2'b10, 0, 9'h040, 0, 64'h0, 64'h0, 0, 0);
    burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
